// File: rtl/fibo_display_if.sv
// Bus between the Fibonacci engine, this display stage and whatever observes it.
// The engine side drives the result and done flag; the display side returns BCD and pins.
interface fibo_display_if;
  logic [7:0]  fibo;
  logic        finished;
  logic [11:0] bcd;
  logic        valid;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output fibo, finished,
    input  bcd, valid, busy, an, seg
  );

  modport slave (
    input  fibo, finished,
    output bcd, valid, busy, an, seg
  );
endinterface

// File: rtl/fibo_display.sv
// Captures the Fibonacci result on a rising edge of finished, converts it to BCD by
// double-dabble and scans it onto a 4-digit common-anode 7-segment display.
module fibo_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic    clk,
  input  logic    reset,
  fibo_display_if.slave bus
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                  state, state_next;
  logic                    fin_q;
  logic [19:0]             shift_reg;
  logic [19:0]             shift_next;
  logic [2:0]              count;
  logic [11:0]             bcd_reg;
  logic                    valid_reg;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic                    capture;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    lit;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift the whole register.
  always_comb begin
    logic [19:0] adjusted;
    adjusted   = {add3(shift_reg[19:16]), add3(shift_reg[15:12]),
                  add3(shift_reg[11:8]), shift_reg[7:0]};
    shift_next = {adjusted[18:0], 1'b0};
  end

  assign capture = bus.finished && !fin_q && (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (capture) state_next = CONV;
      CONV: if (count == 3'd7) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: fin_q tracks every cycle so edges arriving mid-conversion are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_q     <= 1'b0;
      shift_reg <= '0;
      count     <= '0;
      bcd_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      fin_q     <= bus.finished;
      valid_reg <= 1'b0;
      if (state == IDLE) begin
        if (capture) begin
          shift_reg <= {12'b0, bus.fibo};
          count     <= '0;
        end
      end else begin
        shift_reg <= shift_next;
        count     <= count + 3'd1;
        if (count == 3'd7) begin
          bcd_reg   <= shift_next[19:8];
          valid_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) refresh_cnt <= '0;
    else       refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign sel = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // Leading-zero blanking: tens hides only when hundreds is also zero.
  always_comb begin
    digit = 4'hf;
    lit   = 1'b0;
    case (sel)
      2'd0: begin digit = bcd_reg[3:0];  lit = 1'b1;           end
      2'd1: begin digit = bcd_reg[7:4];  lit = |bcd_reg[11:4]; end
      2'd2: begin digit = bcd_reg[11:8]; lit = |bcd_reg[11:8]; end
      default: begin digit = 4'hf; lit = 1'b0; end
    endcase
  end

  assign bus.an    = lit ? ~(4'b0001 << sel) : 4'b1111;
  assign bus.seg   = lit ? seg_code(digit) : 7'b1111111;
  assign bus.bcd   = bcd_reg;
  assign bus.valid = valid_reg;
  assign bus.busy  = (state == CONV);

endmodule

// File: doc/fibo_display.md
# fibo_display

Downstream stage of the Fibonacci engine. It captures the 8-bit `fibo` result when the engine raises `finished` and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) sequencer. It drives a 4-digit multiplexed, common-anode 7-segment display with leading-zero blanking. The display always shows the last completed conversion.

## Interface
- `REFRESH_BITS`, default 18: width of the scan counter. The top 2 bits select the digit, so at 50 MHz each digit is lit for about 1.31 ms.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fibo`  in  8  unsigned result from the Fibonacci engine.
- `finished`  in  1  engine done flag, level. A rising edge marks a new result.
- `bcd`  out  12  last converted value: {hundreds, tens, units}.
- `valid`  out  1  one-cycle pulse when `bcd` is updated.
- `busy`  out  1  high while a conversion is in progress.
- `an`  out  4  digit anodes, active low. `an[0]` is units.
- `seg`  out  7  segments, active low, ordered {g,f,e,d,c,b,a}.

## Operation
- **Edge detect:** `fin_q` registers `finished` every cycle. A capture occurs when `finished`=1, `fin_q`=0 and the state is IDLE. A rising edge in any other state is ignored (not queued).
- **State machine:** IDLE, CONV.
  - IDLE + capture: load shift register `{12'b0, fibo}`, iteration count = 0, go to CONV. `fibo` is sampled only at this edge.
  - CONV, each cycle:
    - for each of the three BCD nibbles, add 3 if the nibble is >= 5;
    - then shift the 20-bit register left by 1;
    - increment the count.
  - CONV, 8th shift (count = 7): load `bcd` with the upper 12 bits of the shifted result, pulse `valid`, return to IDLE.
- **`busy`:** equals (state == CONV).
- **Range:** no overflow is possible, since 255 fits in 3 digits; the hundreds digit is always <= 2.
- **Scan counter:**
  - `REFRESH_BITS` wide, free-running, wraps.
  - `sel` = counter[MSB:MSB-1].
  - `sel` 0/1/2 selects units/tens/hundreds; `sel` 3 is the unused 4th digit.
- **Anode/segment decode:** combinational from the registered `sel` and `bcd`.
  - A lit digit drives `an` = active-low one-hot of `sel`, and `seg` = its digit pattern.
  - A blanked digit or `sel` 3 drives `an`=4'b1111 and `seg`=7'b1111111.
- **Blanking:**
  - Hundreds is blanked if it is 0.
  - Tens is blanked if both hundreds and tens are 0.
  - Units is never blanked.
  - A middle zero (e.g. 100) is shown.
- **Segment codes** (gfedcba, active low):

  | Digit | Code | Digit | Code |
  |---|---|---|---|
  | 0 | 1000000 | 5 | 0010010 |
  | 1 | 1111001 | 6 | 0000010 |
  | 2 | 0100100 | 7 | 1111000 |
  | 3 | 0110000 | 8 | 0000000 |
  | 4 | 0011001 | 9 | 0010000 |

  Any code > 9 gives 1111111.
- **Display source:** the display reads only `bcd`, never the in-flight shift register, so it does not flicker during a conversion.

## Timing
- **Reset values:**
  - state IDLE; `fin_q`=0, shift register 0, `bcd`=12'h000, `valid`=0, `busy`=0, scan counter 0;
  - hence `an`=4'b1110 and `seg`=7'b1000000 (shows "0").
- **Reset mid-CONV:** immediate return to IDLE. `bcd` is cleared to 0 and no `valid` pulse occurs.
- **Latency:** the capture edge is E0. Shifts happen at E1..E8. `bcd` updates and `valid`=1 after E8, and `valid` returns to 0 after E9. `busy` is high from after E0 to after E8 (8 cycles).
- **Back-to-back:**
  - A new capture is possible at E9 if `finished` shows a fresh rising edge. `fin_q` tracks continuously, so an edge seen during CONV is consumed and lost.
  - `finished` held high produces exactly one conversion.
- **Scan timing:** each digit slot lasts 2^(REFRESH_BITS-2) cycles. The full frame is 2^REFRESH_BITS cycles. The counter is not affected by conversions.

## Test plan
All scenarios use `REFRESH_BITS`=4 (4-cycle slots, 16-cycle frame) and T=20 ns.
- **Reset then release:**
  - `an`=1110, `seg`=1000000, `bcd`=000, `busy`=0, `valid`=0;
  - over one frame, `an` sequence 1110,1111,1111,1111.
- **Single small value:** `fibo`=8 (n=6), `finished` 0→1 → `busy` high for 8 cycles, a 1-cycle `valid` after E8, `bcd`=12'h008; units `seg`=0000000, tens/hundreds slots blank.
- **Three-digit values:**
  - `fibo`=233 → `bcd`=12'h233, slot digits 3,3,2 (`seg` 0110000, 0110000, 0100100).
  - `fibo`=255 → `bcd`=12'h255.
  - `fibo`=100 → `bcd`=12'h100, with the tens '0' displayed, not blanked.
- **Held/retriggered `finished`:** `finished` held high for 20 cycles → exactly one `valid` pulse. A second 0→1 at E3 (during CONV) → ignored, and `bcd` reflects only the first `fibo`. Changing `fibo` after E0 has no effect.
- **Reset mid-conversion:** assert `reset` at E4 with prior `bcd`=12'h013 → `busy`=0, `bcd`=000, no `valid`. After release, `fibo`=21 → `bcd`=12'h021 with the hundreds slot blanked.
